fetch_stage: RTL

- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Presents each fetched instruction, its PC and an 8-bit opcode field to the decode stage through a valid/ready handshake.
- Accepts branch redirects from later stages and discards any stale in-flight fetches.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/if_skid_buf.sv | 64 ++++++
 rtl/fetch_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and opcode-field constants for the instruction-fetch stage.
// No logic of its own; imported by fetch_stage and if_skid_buf.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam int OPC_LSB   = 26;
    localparam int OPC_W     = 6;
    localparam int OPC_EXT_W = 8;

    function automatic logic [OPC_EXT_W-1:0] opc_ext(input logic [OPC_W-1:0] field);
        return {{(OPC_EXT_W-OPC_W){1'b0}}, field};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Output register plus one-entry skid for fetched instructions; a response lands one cycle later.
// Holds output while i_out_rdy=0; a second response parks in the skid and drains on the next transfer.
module if_skid_buf
    import fetch_pkg::*;
#(
    parameter int DAT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_vld,
    input  logic [DAT_W-1:0] i_in_dat,
    input  logic             i_flush,
    input  logic             i_out_rdy,
    output logic             o_out_vld,
    output logic [DAT_W-1:0] o_out_dat,
    output logic             o_skid_full
);

    logic             r_out_vld;
    logic [DAT_W-1:0] r_out_dat;
    logic             r_skid_vld;
    logic [DAT_W-1:0] r_skid_dat;
    logic             w_xfer;

    assign w_xfer = r_out_vld & i_out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
        end else if (i_flush) begin
            // a transfer in this cycle still completes; only the valids drop
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_xfer) begin
            if (r_skid_vld) begin
                r_out_dat  <= r_skid_dat;
                r_skid_vld <= i_in_vld;
                if (i_in_vld) begin
                    r_skid_dat <= i_in_dat;
                end
            end else if (i_in_vld) begin
                r_out_dat <= i_in_dat;
            end else begin
                r_out_vld <= 1'b0;
            end
        end else if (!r_out_vld) begin
            if (i_in_vld) begin
                r_out_vld <= 1'b1;
                r_out_dat <= i_in_dat;
            end
        end else if (i_in_vld) begin
            r_skid_vld <= 1'b1;
            r_skid_dat <= i_in_dat;
        end
    end

    assign o_out_vld   = r_out_vld;
    assign o_out_dat   = r_out_dat;
    assign o_skid_full = r_skid_vld;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem requests, redirect kill of stale fetches, valid/ready to decode.
// Latency one cycle from imem_rvalid to if_valid; stalls fetching while the skid is full. FETCH_STAT_EN adds fetch_cnt.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_ack,
    input  logic                 imem_rvalid,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    input  logic                 id_ready,
    output logic                 if_valid,
    output logic [INSTR_W-1:0]   if_instr,
    output logic [ADDR_W-1:0]    if_pc,
    output logic [OPC_EXT_W-1:0] if_opcode,
    output logic [15:0]          fetch_cnt
);

    localparam int DAT_W = INSTR_W + ADDR_W;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_kill;
    logic              w_kill_nxt;
    logic              w_imem_req;
    logic              w_resp;
    logic              w_to_skid;
    logic              w_skid_full;
    logic [DAT_W-1:0]  w_out_dat;

    assign w_resp    = (r_state == WAIT) & imem_rvalid & ~r_kill & ~redirect_valid;
    assign w_to_skid = w_resp & if_valid & ~id_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_imem_req  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_skid_full) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_state_nxt = WAIT;
                    if (!r_kill) begin
                        w_pc_nxt = r_pc + ADDR_W'(PC_STEP);
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // skip IDLE when the skid stays empty, keeping 2 cycles per fetch
                    w_state_nxt = w_to_skid ? IDLE : REQ;
                    w_kill_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (redirect_valid) begin
            w_pc_nxt = redirect_pc;
            if ((r_state == REQ) || ((r_state == WAIT) && !imem_rvalid)) begin
                w_kill_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req_addr <= '0;
            r_kill     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
            // address is frozen while a request is presented, even across a redirect
            if (r_state != REQ) begin
                r_addr <= w_pc_nxt;
            end
            if ((r_state == REQ) && imem_ack) begin
                r_req_addr <= r_addr;
            end
        end
    end

    assign imem_req  = w_imem_req;
    assign imem_addr = r_addr;

    if_skid_buf #(
        .DAT_W (DAT_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_vld    (w_resp),
        .i_in_dat    ({imem_rdata, r_req_addr}),
        .i_flush     (redirect_valid),
        .i_out_rdy   (id_ready),
        .o_out_vld   (if_valid),
        .o_out_dat   (w_out_dat),
        .o_skid_full (w_skid_full)
    );

    assign if_instr  = w_out_dat[DAT_W-1:ADDR_W];
    assign if_pc     = w_out_dat[ADDR_W-1:0];
    assign if_opcode = opc_ext(if_instr[OPC_LSB +: OPC_W]);

`ifdef FETCH_STAT_EN
    logic [15:0] r_fetch_cnt;
    logic        w_xfer;

    assign w_xfer = if_valid & id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
        end else if (w_xfer) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`else
    assign fetch_cnt = '0;
`endif

endmodule
